sseg_orbit_animator: RTL and testbench

//  Animates a "box orbit" across NUM_DIGITS multiplexed seven-segment digits.
//  - Upper box (a,b,f,g) sweeps left to right across the digits.
//  - Lower box (c,d,e,g) then sweeps right to left.

---
 rtl/sseg_orbit_animator_pkg.sv | 24 ++
 rtl/sseg_orbit_animator_if.sv | 22 ++
 rtl/sseg_orbit_animator_scan_mux.sv | 44 ++++
 rtl/sseg_orbit_animator.sv | 78 +++++++
 tb/tb_sseg_orbit_animator.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sseg_orbit_animator_pkg.sv
// Shared segment types, glyph constants and the orbit-position-to-frame decoder
// used by the animator top and its scan multiplexer.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK     = 7'h7F;
  localparam seg_t SEG_UPPER_BOX = 7'b0011100;
  localparam seg_t SEG_LOWER_BOX = 7'b0100011;
  localparam int   MAX_DIGITS    = 8;

  // Returns a frame sized for MAX_DIGITS; callers keep the low 7*n bits.
  // Positions 0..n-1 light the upper box from the leftmost digit rightwards,
  // positions n..2n-1 light the lower box from the rightmost digit leftwards.
  function automatic logic [7*MAX_DIGITS-1:0] orbit_frame(input int unsigned pos,
                                                          input int unsigned n);
    logic [7*MAX_DIGITS-1:0] f;
    f = {MAX_DIGITS{SEG_BLANK}};
    if (pos < n) f[7*(n-1-pos) +: 7] = SEG_UPPER_BOX;
    else         f[7*(pos-n) +: 7]   = SEG_LOWER_BOX;
    return f;
  endfunction

endpackage

// File: rtl/sseg_orbit_animator_if.sv
// Control inputs and display outputs of the orbit animator.
// Controls are level inputs sampled on every rising clock edge; no handshake,
// step_now is a single-cycle pulse and wrap is a single-cycle strobe.
interface sseg_orbit_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int POS_W = $clog2(2*NUM_DIGITS);

  logic                    run;
  logic                    dir;
  logic                    step_now;
  logic [POS_W-1:0]        pos;
  logic                    wrap;
  logic [7*NUM_DIGITS-1:0] frame;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (output run, dir, step_now,
                  input  pos, wrap, frame, seg, an);
  modport slave  (input  run, dir, step_now,
                  output pos, wrap, frame, seg, an);
endinterface

// File: rtl/sseg_orbit_animator_scan_mux.sv
// Time-multiplexes a full frame onto one set of segment pins, one digit per
// SCAN_DIV-clock slot; seg and an are registered together so they never skew.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] i_frame,
  output seg_t                    o_seg,
  output logic [NUM_DIGITS-1:0]   o_an
);
  localparam int CNT_W = $clog2(SCAN_DIV) + 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  seg_t                  r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  w_slot_end;

  assign w_slot_end = (r_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
      if (w_slot_end)
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      r_seg <= i_frame[7*32'(r_idx) +: 7];
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  assign o_seg = r_seg;
  assign o_an  = r_an;

endmodule

// File: rtl/sseg_orbit_animator.sv
// Box-orbit animator: step prescaler, orbit position with wrap strobe,
// registered frame decode, and the digit scan multiplexer.
module sseg_orbit_animator
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input logic         clk,
  input logic         reset,
  sseg_orbit_if.slave bus
);
  localparam int POS_W = $clog2(2*NUM_DIGITS);
  localparam int PRE_W = $clog2(STEP_DIV);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2*NUM_DIGITS - 1);

  logic [PRE_W-1:0]          r_presc;
  logic [POS_W-1:0]          r_pos;
  logic                      r_wrap;
  logic [7*NUM_DIGITS-1:0]   r_frame;
  logic                      w_tick;
  logic                      w_adv;
  logic [POS_W-1:0]          w_pos_next;
  logic                      w_wraps;
  logic [7*MAX_DIGITS-1:0]   w_frame_full;
  logic [7*MAX_DIGITS-1:0]   w_frame_rst;

  assign w_tick = bus.run && (r_presc == PRE_W'(STEP_DIV - 1));
  assign w_adv  = w_tick || bus.step_now;

  // Explicit mod-2N arithmetic; 2N need not be a power of two.
  always_comb begin
    w_pos_next = r_pos;
    w_wraps    = 1'b0;
    if (!bus.dir) begin
      w_wraps    = (r_pos == POS_LAST);
      w_pos_next = w_wraps ? '0 : r_pos + POS_W'(1);
    end else begin
      w_wraps    = (r_pos == '0);
      w_pos_next = w_wraps ? POS_LAST : r_pos - POS_W'(1);
    end
  end

  assign w_frame_full = orbit_frame(32'(r_pos), NUM_DIGITS);
  assign w_frame_rst  = orbit_frame(32'd0, NUM_DIGITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_pos   <= '0;
      r_wrap  <= 1'b0;
      r_frame <= w_frame_rst[7*NUM_DIGITS-1:0];
    end else begin
      if (w_adv)        r_presc <= '0;
      else if (bus.run) r_presc <= r_presc + PRE_W'(1);
      if (w_adv) r_pos <= w_pos_next;
      r_wrap  <= w_adv && w_wraps;
      r_frame <= w_frame_full[7*NUM_DIGITS-1:0];
    end
  end

  assign bus.pos   = r_pos;
  assign bus.wrap  = r_wrap;
  assign bus.frame = r_frame;

  sseg_scan_mux #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .i_frame(r_frame),
    .o_seg  (bus.seg),
    .o_an   (bus.an)
  );

endmodule

// File: tb/tb_sseg_orbit_animator.sv
// Randomized bench for sseg_orbit_animator against a cycle-level behavioural
// model of orbit stepping, frame decode and digit scanning.
module tb_sseg_orbit_animator;
  localparam int N        = 4;
  localparam int STEP_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int W        = 64;

  logic clk;
  logic reset;
  logic t_run, t_dir, t_step;
  int   n_total, n_bad;

  // scoreboard / model state
  int         m_pos, m_cnt, m_sc, m_idx;
  logic       m_wrap;
  logic [27:0] m_frame;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic [W-1:0] exp_q[$];

  sseg_orbit_if #(.NUM_DIGITS(N)) bus ();

  assign bus.run      = t_run;
  assign bus.dir      = t_dir;
  assign bus.step_now = t_step;

  sseg_orbit_animator #(
    .NUM_DIGITS(N),
    .STEP_DIV  (STEP_DIV),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame built digit by digit from the orbit description.
  function automatic logic [27:0] frame_of(input int p);
    logic [6:0] dig [N];
    logic [27:0] f;
    for (int i = 0; i < N; i++) dig[i] = 7'h7F;
    if (p < N) dig[N-1-p] = 7'b0011100;
    else       dig[p-N]   = 7'b0100011;
    f = '0;
    for (int i = 0; i < N; i++) f = f | (28'(dig[i]) << (7*i));
    return f;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_sc = 0; m_idx = 0;
    m_wrap = 1'b0;
    m_frame = frame_of(0);
    m_seg = 7'h7F;
    m_an = 4'hF;
  endtask

  task automatic model_update();
    logic [27:0] nf;
    logic [6:0]  ns;
    logic [3:0]  na;
    logic        tick;
    nf = frame_of(m_pos);
    ns = 7'((m_frame >> (7*m_idx)) & 28'h7F);
    na = ~(4'b0001 << m_idx);
    if (m_sc == SCAN_DIV - 1) begin
      m_sc = 0;
      m_idx = (m_idx + 1) % N;
    end else m_sc++;
    tick = t_run && (m_cnt == STEP_DIV - 1);
    m_wrap = 1'b0;
    if (tick || t_step) begin
      if (!t_dir) begin
        m_wrap = (m_pos == 2*N - 1);
        m_pos  = (m_pos + 1) % (2*N);
      end else begin
        m_wrap = (m_pos == 0);
        m_pos  = (m_pos + 2*N - 1) % (2*N);
      end
      m_cnt = 0;
    end else if (t_run) m_cnt++;
    m_frame = nf;
    m_seg = ns;
    m_an = na;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step_clk();
    @(posedge clk);
    model_update();
    exp_q.push_back(W'(m_pos));
    #1;
    check_val("pos", W'(bus.pos), exp_q.pop_front());
    check_val("wrap", W'(bus.wrap), W'(m_wrap));
    check_val("frame", W'(bus.frame), W'(m_frame));
    check_val("seg", W'(bus.seg), W'(m_seg));
    check_val("an", W'(bus.an), W'(m_an));
  endtask

  // Asserts reset between edges and checks the asynchronous clear immediately.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("rst_pos", W'(bus.pos), W'(0));
    check_val("rst_wrap", W'(bus.wrap), W'(0));
    check_val("rst_seg", W'(bus.seg), W'(7'h7F));
    check_val("rst_an", W'(bus.an), W'(4'hF));
    check_val("rst_frame", W'(bus.frame), W'(28'h39FFFFF));
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    reset = 1'b1;
    t_run = 1'b0; t_dir = 1'b0; t_step = 1'b0;
    model_reset();
    apply_reset();

    // free-running forward orbit through a full wrap
    t_run = 1'b1;
    for (int i = 0; i < 40; i++) step_clk();
    check_val("fwd_pos_after_40", W'(bus.pos), W'(2));

    // reverse from the current position, crossing 0 -> 2N-1
    t_dir = 1'b1;
    for (int i = 0; i < 20; i++) step_clk();

    // pause for 20 clocks then resume
    t_run = 1'b0;
    for (int i = 0; i < 20; i++) step_clk();
    t_run = 1'b1;
    for (int i = 0; i < 6; i++) step_clk();

    // single steps while paused, forward
    t_run = 1'b0; t_dir = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t_step = (i % 3 == 0);
      step_clk();
    end
    t_step = 1'b0;

    // step_now coincident with a tick must give one step
    t_run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_step = (m_cnt == STEP_DIV - 1);
      step_clk();
    end
    t_step = 1'b0;

    // randomized run / dir / step_now
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) t_run = ~t_run;
      if ($urandom_range(0, 9) == 0)  t_dir = ~t_dir;
      t_step = ($urandom_range(0, 7) == 0);
      step_clk();
      if (i == 200) begin
        t_step = 1'b0;
        apply_reset();
      end
    end
    t_step = 1'b0;

    // reset mid-step, then confirm first step lands STEP_DIV clocks after run
    t_run = 1'b1; t_dir = 1'b0;
    apply_reset();
    for (int i = 0; i < STEP_DIV - 1; i++) step_clk();
    check_val("pre_first_step", W'(bus.pos), W'(0));
    step_clk();
    check_val("first_step", W'(bus.pos), W'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
